// File: rtl/alu_uart_interface_if.sv
// Bus between the UART byte stream, the ALU and the transmitter. The slave side is the sequencer.
// The master side drives the receive, ALU and tx-done inputs and observes the operands and tx controls.
interface alu_uart_interface_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_data_a;
  logic [DATA_WIDTH-1:0] o_data_b;
  logic [OP_WIDTH-1:0]   o_opcode;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_timeout;

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes, feeds the ALU, then launches uart_tx 2 clocks after the opcode byte.
// No backpressure: bytes arriving while busy are dropped; an inter-byte gap timeout discards partial sequences.
module alu_uart_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 260400
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_uart_interface_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic                  gap_expired;

  assign gap_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (bus.i_rx_done) begin
          data_a_d = bus.i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.i_rx_done) begin
          data_b_d = bus.i_rx_data;
          state_d  = WAIT_OP;
        end else if (gap_expired) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_OP: begin
        // A byte arriving on the expiry cycle still wins over the timeout.
        if (bus.i_rx_done) begin
          opcode_d = bus.i_rx_data[OP_WIDTH-1:0];
          busy_d   = 1'b1;
          state_d  = EXEC;
        end else if (gap_expired) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_opcode   = opcode_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
endmodule
